// File: rtl/fb_scanout_if.sv
// Frame-buffer BRAM read port seen by the scanout engine.
// master = scanout side (drives address/enable), slave = memory side.
interface fb_scanout_if;
  logic [31:0] buffer_addr;
  logic [31:0] buffer_din;
  logic [31:0] buffer_dout;
  logic        buffer_en;
  logic        buffer_rst;
  logic [3:0]  buffer_we;

  modport master (
    output buffer_addr, buffer_din, buffer_en, buffer_rst, buffer_we,
    input  buffer_dout
  );

  modport slave (
    input  buffer_addr, buffer_din, buffer_en, buffer_rst, buffer_we,
    output buffer_dout
  );
endinterface

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: VGA timing, incremental BRAM fetch, pixel unpack/replication.
// Optional FB_DOUBLE_BUFFER_EN adds tear-free frame_sel / frame_sel_active ports.
module fb_scanout #(
  parameter int          H_VIS_AREA_PXL            = 800,
  parameter int          H_FRONT_PORCH_PXL         = 40,
  parameter int          H_SYNC_PULSE_PXL          = 128,
  parameter int          H_BACK_PORCH_PXL          = 88,
  parameter int          H_NUM_BITS                = 11,
  parameter int          V_VIS_AREA_PXL            = 600,
  parameter int          V_FRONT_PORCH_PXL         = 1,
  parameter int          V_SYNC_PULSE_PXL          = 4,
  parameter int          V_BACK_PORCH_PXL          = 23,
  parameter int          V_NUM_BITS                = 10,
  parameter int          DOWNSCALE_SHIFT           = 1,
  parameter int          CHANNEL_BITS              = 2,
  parameter int          PIXEL_BITS                = 8,
  parameter int          FRAME_BUFFER_READ_LATENCY = 1,
  parameter logic [31:0] FRAME_BASE_ADDR           = 32'h0
) (
  input  logic            vga_clk,
  input  logic            resetn,
  fb_scanout_if.master    fb,
  output logic [3:0]      VGA_R,
  output logic [3:0]      VGA_G,
  output logic [3:0]      VGA_B,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            frame_start
`ifdef FB_DOUBLE_BUFFER_EN
  ,
  input  logic            frame_sel,
  output logic            frame_sel_active
`endif
);

  localparam int H_TOTAL = H_VIS_AREA_PXL + H_FRONT_PORCH_PXL + H_SYNC_PULSE_PXL + H_BACK_PORCH_PXL;
  localparam int V_TOTAL = V_VIS_AREA_PXL + V_FRONT_PORCH_PXL + V_SYNC_PULSE_PXL + V_BACK_PORCH_PXL;
  localparam int REP     = 1 << DOWNSCALE_SHIFT;
  localparam int SRC_W   = H_VIS_AREA_PXL >> DOWNSCALE_SHIFT;
  localparam int SRC_H   = V_VIS_AREA_PXL >> DOWNSCALE_SHIFT;
  localparam int PPW     = 32 / PIXEL_BITS;
  localparam int IDX_W   = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int RW      = (DOWNSCALE_SHIFT > 0) ? DOWNSCALE_SHIFT : 1;
  localparam int L       = FRAME_BUFFER_READ_LATENCY;

  localparam logic [31:0] LINE_BYTES  = 32'(SRC_W * PIXEL_BITS / 8);
  localparam logic [31:0] FRAME_BYTES = 32'(SRC_W * SRC_H * PIXEL_BITS / 8);

  localparam logic [H_NUM_BITS-1:0] H_LAST     = H_NUM_BITS'(H_TOTAL - 1);
  localparam logic [H_NUM_BITS-1:0] H_VIS      = H_NUM_BITS'(H_VIS_AREA_PXL);
  localparam logic [H_NUM_BITS-1:0] H_VIS_LAST = H_NUM_BITS'(H_VIS_AREA_PXL - 1);
  localparam logic [H_NUM_BITS-1:0] HS_START   = H_NUM_BITS'(H_VIS_AREA_PXL + H_FRONT_PORCH_PXL);
  localparam logic [H_NUM_BITS-1:0] HS_END     = H_NUM_BITS'(H_VIS_AREA_PXL + H_FRONT_PORCH_PXL + H_SYNC_PULSE_PXL);
  localparam logic [V_NUM_BITS-1:0] V_LAST     = V_NUM_BITS'(V_TOTAL - 1);
  localparam logic [V_NUM_BITS-1:0] V_VIS      = V_NUM_BITS'(V_VIS_AREA_PXL);
  localparam logic [V_NUM_BITS-1:0] VS_START   = V_NUM_BITS'(V_VIS_AREA_PXL + V_FRONT_PORCH_PXL);
  localparam logic [V_NUM_BITS-1:0] VS_END     = V_NUM_BITS'(V_VIS_AREA_PXL + V_FRONT_PORCH_PXL + V_SYNC_PULSE_PXL);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(PPW - 1);
  localparam logic [RW-1:0]         REP_LAST   = RW'(REP - 1);

  if ((SRC_W * PIXEL_BITS) % 32 != 0) begin : g_bad_geometry
    $error("fb_scanout: SRC_W*PIXEL_BITS must be a multiple of 32");
  end
  if (PIXEL_BITS < 3 * CHANNEL_BITS) begin : g_bad_pixel
    $error("fb_scanout: PIXEL_BITS must hold three channels");
  end

  typedef struct packed {
    logic             vis;
    logic             hs;
    logic             vs;
    logic             fs;
    logic [IDX_W-1:0] idx;
  } pipe_t;

  logic [H_NUM_BITS-1:0] h_q, h_d;
  logic [V_NUM_BITS-1:0] v_q, v_d;
  logic                  run_q, run_d;
  logic [31:0]           ptr_q, ptr_d;
  logic [31:0]           hold_q, hold_d;
  logic [31:0]           line_base_q, line_base_d;
  logic [RW-1:0]         lrep_q, lrep_d;
  logic [RW-1:0]         prep_q, prep_d;
  logic [IDX_W-1:0]      sub_q, sub_d;
  logic                  sel_q, sel_d;
  pipe_t                 pipe_q [L];
  pipe_t                 pipe_d [L];
  logic [3:0]            r_q, r_d, g_q, g_d, b_q, b_d;
  logic                  hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

  logic        vis_now;
  logic [31:0] frame_base;

  // run_q holds the counters at (0,0) for one cycle after reset so that
  // buffer_en stays low during reset yet the first running cycle fetches (0,0).
  assign vis_now = run_q && (h_q < H_VIS) && (v_q < V_VIS);

`ifdef FB_DOUBLE_BUFFER_EN
  assign frame_base       = FRAME_BASE_ADDR + (sel_q ? FRAME_BYTES : 32'd0);
  assign frame_sel_active = sel_q;
`else
  assign frame_base       = FRAME_BASE_ADDR;
`endif

  // NOTE: every variable gets a default at the top of an always_comb, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    run_d       = 1'b1;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    line_base_d = line_base_q;
    lrep_d      = lrep_q;
    prep_d      = prep_q;
    sub_d       = sub_q;
    sel_d       = sel_q;

    if (run_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    if (vis_now) begin
      hold_d = ptr_q;
      if (prep_q == REP_LAST) begin
        prep_d = '0;
        if (sub_q == IDX_LAST) begin
          sub_d = '0;
          ptr_d = ptr_q + 32'd4;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end else begin
        prep_d = prep_q + 1'b1;
      end

      // End of a visible line: repeat the source line 2^S times, then step.
      if (h_q == H_VIS_LAST) begin
        prep_d = '0;
        sub_d  = '0;
        if (lrep_q == REP_LAST) begin
          lrep_d      = '0;
          line_base_d = line_base_q + LINE_BYTES;
        end else begin
          lrep_d = lrep_q + 1'b1;
        end
        ptr_d = line_base_d;
      end
    end

    if (run_q && h_q == H_LAST && v_q == V_LAST) begin
      line_base_d = frame_base;
      ptr_d       = frame_base;
      lrep_d      = '0;
      prep_d      = '0;
      sub_d       = '0;
    end

`ifdef FB_DOUBLE_BUFFER_EN
    // Sampled only on v-sync entry, so a frame never mixes two buffers.
    if (run_q && h_q == '0 && v_q == VS_START) sel_d = frame_sel;
`endif
  end

  assign fb.buffer_en   = vis_now;
  assign fb.buffer_addr = vis_now ? ptr_q : hold_q;
  assign fb.buffer_din  = 32'd0;
  assign fb.buffer_rst  = 1'b0;
  assign fb.buffer_we   = 4'd0;

  pipe_t                    tail;
  logic [4:0]               pix_off;
  logic [3*CHANNEL_BITS-1:0] pix;

  function automatic logic [3:0] expand(input logic [CHANNEL_BITS-1:0] c);
    return 4'({4{c}} >> (4 * CHANNEL_BITS - 4));
  endfunction

  always_comb begin
    pipe_d[0].vis = vis_now;
    pipe_d[0].hs  = run_q && (h_q >= HS_START) && (h_q < HS_END);
    pipe_d[0].vs  = run_q && (v_q >= VS_START) && (v_q < VS_END);
    pipe_d[0].fs  = run_q && (h_q == '0) && (v_q == '0);
    pipe_d[0].idx = sub_q;
    for (int i = 1; i < L; i++) pipe_d[i] = pipe_q[i-1];

    tail    = pipe_q[L-1];
    pix_off = 5'(tail.idx * PIXEL_BITS);
    pix     = fb.buffer_dout[pix_off +: 3*CHANNEL_BITS];
    r_d     = tail.vis ? expand(pix[2*CHANNEL_BITS +: CHANNEL_BITS]) : 4'd0;
    g_d     = tail.vis ? expand(pix[CHANNEL_BITS +: CHANNEL_BITS])   : 4'd0;
    b_d     = tail.vis ? expand(pix[0 +: CHANNEL_BITS])              : 4'd0;
    hs_d    = tail.hs;
    vs_d    = tail.vs;
    fs_d    = tail.fs;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge vga_clk or negedge resetn) begin
    if (!resetn) begin
      h_q         <= '0;
      v_q         <= '0;
      run_q       <= 1'b0;
      ptr_q       <= FRAME_BASE_ADDR;
      hold_q      <= FRAME_BASE_ADDR;
      line_base_q <= FRAME_BASE_ADDR;
      lrep_q      <= '0;
      prep_q      <= '0;
      sub_q       <= '0;
      sel_q       <= 1'b0;
      // NOTE: the delay line is reset (it is a handful of flops, not a RAM) so
      // blanking and sync are clean from the first cycle after reset.
      for (int i = 0; i < L; i++) pipe_q[i] <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      run_q       <= run_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      line_base_q <= line_base_d;
      lrep_q      <= lrep_d;
      prep_q      <= prep_d;
      sub_q       <= sub_d;
      sel_q       <= sel_d;
      for (int i = 0; i < L; i++) pipe_q[i] <= pipe_d[i];
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
    end
  end

  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: two configurations (S=0/L=1/CB=2 and S=1/L=3/CB=1) on reduced
// timing, compared every cycle against an arithmetic model of the scan geometry.
module tb_fb_scanout;

  localparam int HV = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VV = 4, VF = 1, VSW = 1, VB = 1;
  localparam int H_T = HV + HF + HSW + HB;
  localparam int V_T = VV + VF + VSW + VB;
  localparam int FRAME_CYC = H_T * V_T;

  localparam int          CFG_S  [2] = '{0, 1};
  localparam int          CFG_CB [2] = '{2, 1};
  localparam int          CFG_PB [2] = '{8, 8};
  localparam int          CFG_L  [2] = '{1, 3};
  localparam logic [31:0] CFG_FB [2] = '{32'h0, 32'h40};

  typedef struct packed {
    logic        vis;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [31:0] addr;
    logic [4:0]  idx;
  } exp_t;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        act;
  } obs_t;

  logic vga_clk = 1'b0;
  logic resetn;
  logic frame_sel;

  always #5 vga_clk = ~vga_clk;

  fb_scanout_if bus_a ();
  fb_scanout_if bus_b ();

  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
  logic       act_a, act_b;

  fb_scanout #(
    .H_VIS_AREA_PXL(HV), .H_FRONT_PORCH_PXL(HF), .H_SYNC_PULSE_PXL(HSW), .H_BACK_PORCH_PXL(HB),
    .H_NUM_BITS(4),
    .V_VIS_AREA_PXL(VV), .V_FRONT_PORCH_PXL(VF), .V_SYNC_PULSE_PXL(VSW), .V_BACK_PORCH_PXL(VB),
    .V_NUM_BITS(3),
    .DOWNSCALE_SHIFT(CFG_S[0]), .CHANNEL_BITS(CFG_CB[0]), .PIXEL_BITS(CFG_PB[0]),
    .FRAME_BUFFER_READ_LATENCY(CFG_L[0]), .FRAME_BASE_ADDR(CFG_FB[0])
  ) u_dut_a (
    .vga_clk(vga_clk), .resetn(resetn), .fb(bus_a.master),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
    .frame_start(fs_a)
`ifdef FB_DOUBLE_BUFFER_EN
    , .frame_sel(frame_sel), .frame_sel_active(act_a)
`endif
  );

  fb_scanout #(
    .H_VIS_AREA_PXL(HV), .H_FRONT_PORCH_PXL(HF), .H_SYNC_PULSE_PXL(HSW), .H_BACK_PORCH_PXL(HB),
    .H_NUM_BITS(4),
    .V_VIS_AREA_PXL(VV), .V_FRONT_PORCH_PXL(VF), .V_SYNC_PULSE_PXL(VSW), .V_BACK_PORCH_PXL(VB),
    .V_NUM_BITS(3),
    .DOWNSCALE_SHIFT(CFG_S[1]), .CHANNEL_BITS(CFG_CB[1]), .PIXEL_BITS(CFG_PB[1]),
    .FRAME_BUFFER_READ_LATENCY(CFG_L[1]), .FRAME_BASE_ADDR(CFG_FB[1])
  ) u_dut_b (
    .vga_clk(vga_clk), .resetn(resetn), .fb(bus_b.master),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .frame_start(fs_b)
`ifdef FB_DOUBLE_BUFFER_EN
    , .frame_sel(frame_sel), .frame_sel_active(act_b)
`endif
  );

`ifndef FB_DOUBLE_BUFFER_EN
  assign act_a = 1'b0;
  assign act_b = 1'b0;
`endif

  // Shared frame-buffer contents; each port has its own address delay line.
  logic [31:0] mem [64];
  logic [31:0] ap_a [CFG_L[0]];
  logic [31:0] ap_b [CFG_L[1]];

  always @(posedge vga_clk) begin
    ap_a[0] <= bus_a.buffer_addr;
    for (int i = 1; i < CFG_L[0]; i++) ap_a[i] <= ap_a[i-1];
    ap_b[0] <= bus_b.buffer_addr;
    for (int i = 1; i < CFG_L[1]; i++) ap_b[i] <= ap_b[i-1];
  end

  logic [31:0] tail_a, tail_b;
  assign tail_a = ap_a[CFG_L[0]-1];
  assign tail_b = ap_b[CFG_L[1]-1];
  assign bus_a.buffer_dout = mem[tail_a[7:2]];
  assign bus_b.buffer_dout = mem[tail_b[7:2]];

  obs_t obs [2];
  assign obs[0] = {bus_a.buffer_en, bus_a.buffer_addr, r_a, g_a, b_a, hs_a, vs_a, fs_a, act_a};
  assign obs[1] = {bus_b.buffer_en, bus_b.buffer_addr, r_b, g_b, b_b, hs_b, vs_b, fs_b, act_b};

  // Reference-model state.
  int          n_cmp = 0;
  int          n_bad = 0;
  int          k;
  exp_t        hist [2][2048];
  logic [31:0] base_m [2];
  logic [31:0] last_addr_m [2];
  logic        act_m [2];
  logic        pend_m [2];
  logic        pend_v [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] frame_bytes(input int id);
    return 32'(((HV >> CFG_S[id]) * (VV >> CFG_S[id]) * CFG_PB[id]) / 8);
  endfunction

  function automatic logic [31:0] frame_base(input int id);
`ifdef FB_DOUBLE_BUFFER_EN
    return CFG_FB[id] + (act_m[id] ? frame_bytes(id) : 32'd0);
`else
    return CFG_FB[id];
`endif
  endfunction

  // Expected fetch/sync state for the n-th running cycle, from raster geometry.
  function automatic exp_t model_state(input int id, input int n, input logic [31:0] base);
    exp_t e;
    int h, v, s, pb, px, line_bytes;
    h  = n % H_T;
    v  = (n / H_T) % V_T;
    s  = CFG_S[id];
    pb = CFG_PB[id];
    px = h >> s;
    line_bytes = (HV >> s) * pb / 8;
    e.vis  = (h < HV) && (v < VV);
    e.addr = base + 32'((v >> s) * line_bytes + ((px * pb) / 32) * 4);
    e.idx  = 5'(((px * pb) % 32) / pb);
    e.hs   = (h >= HV + HF) && (h < HV + HF + HSW);
    e.vs   = (v >= VV + VF) && (v < VV + VF + VSW);
    e.fs   = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic int expand(input int ch, input int cb);
    int rep, w;
    rep = ch;
    w   = cb;
    while (w < 4) begin
      rep = (rep << cb) | ch;
      w   = w + cb;
    end
    return (rep >> (w - 4)) & 15;
  endfunction

  function automatic logic [11:0] pin_rgb(input int id, input exp_t p);
    longint word, pix;
    int cb, msk, r, g, b;
    if (!p.vis) return 12'h000;
    word = longint'(mem[p.addr[7:2]]);
    pix  = (word >> (int'(p.idx) * CFG_PB[id])) & ((64'd1 << CFG_PB[id]) - 1);
    cb   = CFG_CB[id];
    msk  = (1 << cb) - 1;
    r    = int'(pix >> (2 * cb)) & msk;
    g    = int'(pix >> cb) & msk;
    b    = int'(pix) & msk;
    return 12'((expand(r, cb) << 8) | (expand(g, cb) << 4) | expand(b, cb));
  endfunction

  task automatic reset_model();
    k = 0;
    for (int id = 0; id < 2; id++) begin
      base_m[id]      = CFG_FB[id];
      last_addr_m[id] = CFG_FB[id];
      act_m[id]       = 1'b0;
      pend_v[id]      = 1'b0;
      pend_m[id]      = 1'b0;
    end
  endtask

  task automatic step_check(input int id);
    exp_t        e, p;
    logic [31:0] exp_addr;
    int          m, n;
    e = '0;
    p = '0;
    exp_addr = CFG_FB[id];
    if (k > 0) begin
      n = k - 1;
      if (n % FRAME_CYC == 0) base_m[id] = frame_base(id);
      e = model_state(id, n, base_m[id]);
      hist[id][n] = e;
      exp_addr = e.vis ? e.addr : last_addr_m[id];
      if (e.vis) last_addr_m[id] = e.addr;
      if ((n % H_T == 0) && ((n / H_T) % V_T == VV + VF)) begin
        pend_m[id] = frame_sel;
        pend_v[id] = 1'b1;
      end
    end
    m = k - CFG_L[id] - 2;
    if (m >= 0) p = hist[id][m];
    check($sformatf("u%0d.buffer_en", id), 32'(obs[id].en), 32'(e.vis));
    check($sformatf("u%0d.buffer_addr", id), obs[id].addr, exp_addr);
    check($sformatf("u%0d.rgb", id), 32'(obs[id].rgb), 32'(pin_rgb(id, p)));
    check($sformatf("u%0d.hs", id), 32'(obs[id].hs), 32'(p.hs));
    check($sformatf("u%0d.vs", id), 32'(obs[id].vs), 32'(p.vs));
    check($sformatf("u%0d.frame_start", id), 32'(obs[id].fs), 32'(p.fs));
`ifdef FB_DOUBLE_BUFFER_EN
    check($sformatf("u%0d.frame_sel_active", id), 32'(obs[id].act), 32'(act_m[id]));
`endif
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic run_cycles(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      if ($urandom_range(0, 5) == 0) frame_sel = ~frame_sel;
      step_check(0);
      step_check(1);
      @(posedge vga_clk);
      k++;
      for (int id = 0; id < 2; id++) begin
        if (pend_v[id]) begin
          act_m[id]  = pend_m[id];
          pend_v[id] = 1'b0;
        end
      end
      @(negedge vga_clk);
    end
  endtask

  task automatic mid_line_reset();
    int t;
    t = 0;
    while (!obs[0].en && t < 200) begin
      run_cycles(1);
      t++;
    end
    if (!obs[0].en) check("wait_buffer_en", 32'd0, 32'd1);
    #2 resetn = 1'b0;
    #1;
    for (int id = 0; id < 2; id++) begin
      check($sformatf("u%0d.rst_en", id), 32'(obs[id].en), 32'd0);
      check($sformatf("u%0d.rst_addr", id), obs[id].addr, CFG_FB[id]);
      check($sformatf("u%0d.rst_rgb", id), 32'(obs[id].rgb), 32'd0);
      check($sformatf("u%0d.rst_sync", id), 32'({obs[id].hs, obs[id].vs, obs[id].fs, obs[id].act}), 32'd0);
    end
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    repeat (2) @(negedge vga_clk);
    resetn = 1'b1;
    reset_model();
  endtask

  initial begin
    resetn    = 1'b0;
    frame_sel = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h04030201;
    repeat (3) @(negedge vga_clk);
    for (int id = 0; id < 2; id++)
      check($sformatf("u%0d.in_reset", id), 32'(obs[id]), 32'({1'b0, CFG_FB[id], 16'h0}));
    resetn = 1'b1;
    reset_model();
    run_cycles(450);

    run_cycles($urandom_range(20, 60));
    mid_line_reset();
    run_cycles(520);

    run_cycles($urandom_range(5, 40));
    mid_line_reset();
    run_cycles(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
